// File: rtl/snn_image_loader_if.sv
// Handshake and data signals between the SNN image loader and its
// neighbours: UART receiver, input-unit RAM, inference core and UART transmitter.
interface snn_image_loader_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [9:0] ram_addr;
    logic       ram_d;
    logic       ram_we;
    logic       core_start;
    logic       core_done;
    logic [3:0] core_digit;
    logic       tx_rdy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic [3:0] digit;
    logic       overrun;

    modport slave (
        input  rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        output ram_addr, ram_d, ram_we, core_start, tx_start, tx_data,
        output busy, digit, overrun
    );

    modport master (
        output rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        input  ram_addr, ram_d, ram_we, core_start, tx_start, tx_data,
        input  busy, digit, overrun
    );
endinterface

// File: rtl/snn_image_loader.sv
// Unpacks received image bytes into single-pixel RAM writes, launches the
// SNN inference core on a full frame and sends the result digit as ASCII.
module snn_image_loader #(
    parameter int         NUM_PIXELS = 784,
    parameter logic [7:0] ASCII_BASE = 8'h30
) (
    input  logic               clk,
    input  logic               rst,
    snn_image_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_START,
        S_WAIT_DONE,
        S_SEND
    } state_t;

    localparam logic [9:0] LAST_PIX = 10'(NUM_PIXELS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_hold;
    logic [2:0] r_bitcnt;
    logic [9:0] r_pix;
    logic [3:0] r_digit;
    logic       r_overrun;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    // NOTE: reset is synchronous, so it is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next         = r_state;
        bus.ram_we     = 1'b0;
        bus.ram_d      = 1'b0;
        bus.ram_addr   = r_pix;
        bus.core_start = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        bus.tx_start   = r_tx_start;
        bus.tx_data    = r_tx_data;
        bus.digit      = r_digit;
        bus.overrun    = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_rdy) w_next = S_UNPACK;
            end
            S_UNPACK: begin
                bus.ram_we = 1'b1;
                bus.ram_d  = r_hold[r_bitcnt];
                if (r_bitcnt == 3'd7) w_next = (r_pix == LAST_PIX) ? S_START : S_IDLE;
            end
            S_START: begin
                bus.core_start = 1'b1;
                w_next         = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.core_done) w_next = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_rdy) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= '0;
            r_bitcnt   <= '0;
            r_pix      <= '0;
            r_digit    <= '0;
            r_overrun  <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_rdy) begin
                        r_hold   <= bus.rx_data;
                        r_bitcnt <= '0;
                    end
                end
                S_UNPACK: begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    // The last pixel of a frame rewinds the address for the next frame.
                    r_pix    <= (r_pix == LAST_PIX) ? 10'd0 : r_pix + 10'd1;
                end
                S_WAIT_DONE: begin
                    if (bus.core_done) r_digit <= bus.core_digit;
                end
                S_SEND: begin
                    if (bus.tx_rdy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= ASCII_BASE + {4'b0000, r_digit};
                    end
                end
                default: ;
            endcase
            if (bus.rx_rdy && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snn_image_loader.sv
// Randomised self-checking bench for snn_image_loader against a frame-level
// model: expected pixel writes, start latency and ASCII result per frame.
module tb_snn_image_loader;

    localparam int NPIX = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_image_loader_if bus();

    snn_image_loader #(.NUM_PIXELS(NPIX), .ASCII_BASE(8'h30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] addr;
        logic       d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_wr;
    int         n_tests      = 0;
    int         n_fail       = 0;
    int         cyc          = 0;
    int         last_rx_cyc  = 0;
    int         n_core_start = 0;
    int         n_tx         = 0;
    int         m_pix        = 0;
    logic [7:0] last_tx_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observers sample on the falling edge, half a cycle away from the DUT edge.
    always @(negedge clk) begin
        if (bus.rx_rdy) last_rx_cyc = cyc;
        if (bus.ram_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected_addr", 32'(bus.ram_addr), 32'h3ff);
            end else begin
                exp_wr = exp_q.pop_front();
                check("wr_addr", 32'(bus.ram_addr), 32'(exp_wr.addr));
                check("wr_data", 32'(bus.ram_d), 32'(exp_wr.d));
            end
        end
        if (bus.core_start) begin
            n_core_start++;
            check("start_latency", 32'(cyc - last_rx_cyc), 32'd9);
        end
        if (bus.tx_start) begin
            n_tx++;
            last_tx_data = bus.tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit accept);
        if (accept) begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 10'(m_pix + i), d: b[i]});
            m_pix += 8;
            if (m_pix == NPIX) m_pix = 0;
        end
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
        check("rst_ram_d",      32'(bus.ram_d),      32'd0);
        check("rst_ram_we",     32'(bus.ram_we),     32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_tx_start",   32'(bus.tx_start),   32'd0);
        check("rst_tx_data",    32'(bus.tx_data),    32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_digit",      32'(bus.digit),      32'd0);
        check("rst_overrun",    32'(bus.overrun),    32'd0);
    endtask

    task automatic core_done_in_idle(input logic [3:0] expect_digit);
        bus.core_digit = 4'($urandom_range(0, 9));
        bus.core_done  = 1'b1;
        tick();
        bus.core_done  = 1'b0;
        tick();
        check("idle_done_digit", 32'(bus.digit), 32'(expect_digit));
        check("idle_done_busy",  32'(bus.busy),  32'd0);
    endtask

    task automatic run_frame(input logic [3:0] d, input int hold_tx, input bit pat_a5, input int drop_at);
        int         cs0;
        int         tx0;
        logic [7:0] b;
        logic [7:0] exp_ascii;
        cs0       = n_core_start;
        tx0       = n_tx;
        exp_ascii = 8'h30 + {4'h0, d};
        for (int n = 0; n < NPIX / 8; n++) begin
            b = pat_a5 ? 8'hA5 : 8'($urandom);
            send_byte(b, 1'b1);
            if (n == drop_at) begin
                repeat (2) tick();
                send_byte(8'($urandom), 1'b0);
                check("overrun_set", 32'(bus.overrun), 32'd1);
                repeat (8) tick();
            end else if (n != NPIX / 8 - 1) begin
                repeat (pat_a5 ? 19 : $urandom_range(8, 15)) tick();
            end
        end
        for (int i = 0; i < 40 && n_core_start == cs0; i++) tick();
        check("core_start_count", 32'(n_core_start - cs0), 32'd1);
        check("frame_writes_left", 32'(exp_q.size()), 32'd0);
        check("busy_wait_done", 32'(bus.busy), 32'd1);

        bus.tx_rdy = (hold_tx == 0);
        repeat ($urandom_range(0, 4)) tick();
        bus.core_digit = d;
        bus.core_done  = 1'b1;
        tick();
        bus.core_done  = 1'b0;
        bus.core_digit = 4'($urandom);
        check("digit_capture", 32'(bus.digit), 32'(d));

        if (hold_tx > 0) begin
            repeat (hold_tx) tick();
            check("tx_held", 32'(n_tx - tx0), 32'd0);
            check("busy_in_send", 32'(bus.busy), 32'd1);
            bus.tx_rdy = 1'b1;
        end
        for (int i = 0; i < 2 && n_tx == tx0; i++) tick();
        check("tx_count", 32'(n_tx - tx0), 32'd1);
        check("tx_data", 32'(last_tx_data), 32'(exp_ascii));
        check("busy_after_tx", 32'(bus.busy), 32'd0);
        bus.tx_rdy = 1'b0;
        repeat (3) tick();
        check("tx_data_hold", 32'(bus.tx_data), 32'(exp_ascii));
        check("core_start_single", 32'(n_core_start - cs0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] d_rand;
        int         cs0;
        bus.rx_rdy     = 1'b0;
        bus.rx_data    = 8'h00;
        bus.core_done  = 1'b0;
        bus.core_digit = 4'h0;
        bus.tx_rdy     = 1'b0;
        rst            = 1'b1;
        repeat (3) tick();
        check_reset_values();
        rst = 1'b0;
        tick();

        core_done_in_idle(4'd0);

        // Fixed-pattern frame with 20-cycle byte spacing and immediate transmit.
        run_frame(4'd7, 0, 1'b1, -1);
        // Random frame with an overrun mid-byte and a stalled transmitter.
        run_frame(4'd3, 50, 1'b0, 10);
        // Back-to-back frame directly after the previous result.
        run_frame(4'd9, 0, 1'b0, -1);

        core_done_in_idle(4'd9);

        // Partial frame aborted by reset in the middle of unpacking.
        cs0 = n_core_start;
        for (int n = 0; n < 41; n++) begin
            send_byte(8'($urandom), 1'b1);
            repeat ((n == 40) ? 3 : 9) tick();
        end
        rst = 1'b1;
        tick();
        check_reset_values();
        rst = 1'b0;
        exp_q.delete();
        m_pix = 0;
        repeat (5) tick();
        check("no_start_partial", 32'(n_core_start - cs0), 32'd0);

        d_rand = 4'($urandom_range(0, 9));
        run_frame(d_rand, $urandom_range(1, 10), 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
